// File: rtl/conf_sram_bridge_pkg.sv
// Shared size encodings, response word layout and lane helpers for the CPU-to-conf bridge.
package conf_sram_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  function automatic logic size_bad(input size_e size, input logic [1:0] off);
    return (size == SZ_RSVD) || ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(input size_e size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/conf_resp_fifo.sv
// Sync FIFO with wrap-bit pointers; head is combinational (zero latency from write to visibility next cycle).
// Push is dropped when full unless a pop frees a slot in the same cycle.
module conf_resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full, do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/conf_sram_bridge.sv
// CPU SRAM-like to conf bus bridge: accept at T, conf_en at T+1, rdata captured T+2, response visible T+3.
// Accepts stall once RESP_DEPTH ops are in flight or queued; responses wait on data_rready.
module conf_sram_bridge
  import conf_sram_bridge_pkg::*;
#(
  parameter int          RESP_DEPTH = 2,
  parameter logic [31:0] ADDR_MASK  = 32'h0000_ffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  input  logic        data_rready,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        conf_en,
  output logic [3:0]  conf_wen,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic [31:0] conf_rdata
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic          s1_vld_q, s1_vld_d, s1_err_q, s1_err_d, s1_wr_q, s1_wr_d;
  logic [3:0]    s1_wen_q, s1_wen_d;
  logic [31:0]   s1_addr_q, s1_addr_d, s1_wdata_q, s1_wdata_d;
  logic          s2_vld_q, s2_vld_d, s2_err_q, s2_err_d, s2_wr_q, s2_wr_d;
  logic [CW-1:0] credit_q, credit_d;
  resp_t         last_q, last_d, push_resp, head_resp;
  logic          accept, req_bad, pop, fifo_empty;

  // Credits count everything between accept and pop, so the FIFO can never overflow.
  assign accept       = data_req && (credit_q < CW'(RESP_DEPTH));
  assign data_addr_ok = accept;

  always_comb begin
    req_bad    = size_bad(size_e'(data_size), data_addr[1:0]);
    s1_vld_d   = accept;
    s1_err_d   = s1_err_q;
    s1_wr_d    = s1_wr_q;
    s1_wen_d   = 4'b0000;
    s1_addr_d  = s1_addr_q;
    s1_wdata_d = s1_wdata_q;
    if (accept) begin
      s1_err_d   = req_bad;
      s1_wr_d    = data_wr;
      s1_wen_d   = (data_wr && !req_bad) ? byte_en(size_e'(data_size), data_addr[1:0]) : 4'b0000;
      s1_addr_d  = data_addr & ADDR_MASK & 32'hffff_fffc;
      s1_wdata_d = wdata_rep(size_e'(data_size), data_wdata);
    end
    s2_vld_d        = s1_vld_q;
    s2_err_d        = s1_err_q;
    s2_wr_d         = s1_wr_q;
    push_resp.err   = s2_err_q;
    push_resp.rdata = (s2_err_q || s2_wr_q) ? 32'h0 : conf_rdata;
    pop             = !fifo_empty && data_rready;
    credit_d        = credit_q + CW'(accept) - CW'(pop);
    last_d          = pop ? head_resp : last_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_vld_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_wen_q   <= '0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_wr_q    <= 1'b0;
      credit_q   <= '0;
      last_q     <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_err_q   <= s1_err_d;
      s1_wr_q    <= s1_wr_d;
      s1_wen_q   <= s1_wen_d;
      s1_addr_q  <= s1_addr_d;
      s1_wdata_q <= s1_wdata_d;
      s2_vld_q   <= s2_vld_d;
      s2_err_q   <= s2_err_d;
      s2_wr_q    <= s2_wr_d;
      credit_q   <= credit_d;
      last_q     <= last_d;
    end
  end

  conf_resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (s2_vld_q),
    .push_dat (push_resp),
    .pop      (pop),
    .head_dat (head_resp),
    .empty    (fifo_empty)
  );

  assign conf_en      = s1_vld_q;
  assign conf_wen     = s1_wen_q;
  assign conf_addr    = s1_addr_q;
  assign conf_wdata   = s1_wdata_q;
  assign data_data_ok = !fifo_empty;
  // With the FIFO empty the outputs fall back to the last popped response.
  assign data_rdata   = fifo_empty ? last_q.rdata : head_resp.rdata;
  assign data_err     = fifo_empty ? last_q.err : head_resp.err;

endmodule

// File: tb/tb_conf_sram_bridge.sv
// Directed bench for conf_sram_bridge: scoreboard queue of expected {err,rdata} popped on each response.
module tb_conf_sram_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_req = 1'b0, data_wr = 1'b0, data_rready = 1'b1;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok, data_err;
  logic [31:0] data_rdata;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr, conf_wdata;
  logic [31:0] conf_rdata = '0;

  int total = 0, bad = 0, resp_cnt = 0, en_cnt = 0, cyc = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  conf_sram_bridge #(.RESP_DEPTH(2), .ADDR_MASK(32'h0000_ffff)) dut (
    .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rready(data_rready), .data_rdata(data_rdata),
    .data_err(data_err), .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
  );

  function automatic logic [31:0] slave_val(input logic [31:0] a);
    return (a == 32'h0000_f000) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [32:0] exp_resp(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    logic mis;
    mis = (size == 2'd3) || ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
    if (mis) return {1'b1, 32'h0};
    if (wr) return 33'h0;
    return {1'b0, slave_val(addr & 32'h0000_fffc)};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave returns data the cycle after conf_en; garbage otherwise so timing slips show up.
  always @(posedge clk) conf_rdata <= conf_en ? slave_val(conf_addr) : 32'hdead_beef;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (conf_en) en_cnt++;

  always @(negedge clk) begin
    if (reset && data_data_ok && data_rready) begin
      resp_cnt++;
      chk("resp_expected", 33'(exp_q.size() != 0), 33'd1);
      if (exp_q.size() != 0) chk("resp_data", {data_err, data_rdata}, exp_q.pop_front());
    end
  end

  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (data_addr_ok) begin
        got = 1'b1;
        exp_q.push_back(exp_resp(wr, size, addr));
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("issue_accepted", 33'(got), 33'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int prev, prev_en, k;
    int acc[4];

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_conf_en", 33'(conf_en), 33'd0);
    chk("rst_conf_wen", 33'(conf_wen), 33'd0);
    chk("rst_conf_addr", 33'(conf_addr), 33'd0);
    chk("rst_conf_wdata", 33'(conf_wdata), 33'd0);
    chk("rst_data_ok", 33'(data_data_ok), 33'd0);
    chk("rst_rdata_err", {data_err, data_rdata}, 33'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Word read with masking and exact response latency.
    issue(1'b0, 2'd2, 32'hbfaf_f000, 32'h0);
    @(negedge clk);
    chk("rd_conf_en", 33'(conf_en), 33'd1);
    chk("rd_conf_addr", 33'(conf_addr), 33'h0_0000_f000);
    chk("rd_conf_wen", 33'(conf_wen), 33'd0);
    @(negedge clk);
    chk("rd_ok_t2", 33'(data_data_ok), 33'd0);
    @(negedge clk);
    chk("rd_ok_t3", 33'(data_data_ok), 33'd1);
    drain();

    // Byte write lane enable and replication.
    prev = resp_cnt;
    issue(1'b1, 2'd0, 32'hbfaf_f002, 32'h0000_00ab);
    @(negedge clk);
    chk("bw_conf_en", 33'(conf_en), 33'd1);
    chk("bw_conf_wen", 33'(conf_wen), 33'b0100);
    chk("bw_conf_wdata", 33'(conf_wdata), 33'h0_abab_abab);
    drain();
    chk("bw_resp_count", 33'(resp_cnt - prev), 33'd1);

    // Half write at lane 2.
    issue(1'b1, 2'd1, 32'h0000_0102, 32'h0000_beef);
    @(negedge clk);
    chk("hw_conf_wen", 33'(conf_wen), 33'b1100);
    chk("hw_conf_wdata", 33'(conf_wdata), 33'h0_beef_beef);
    drain();

    // Four back-to-back reads: credit stall after two accepts.
    prev = resp_cnt; prev_en = en_cnt; k = 0;
    acc = '{default: 0};
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (data_addr_ok) begin
        acc[k] = cyc;
        exp_q.push_back(exp_resp(1'b0, 2'd2, data_addr));
        k++;
      end
      @(posedge clk); #1;
      data_addr = 32'h0000_1000 + 32'(k) * 32'd4;
      data_req  = (k < 4);
    end
    chk("b2b_accepts", 33'(k), 33'd4);
    chk("b2b_gap01", 33'(acc[1] - acc[0]), 33'd1);
    chk("b2b_gap12", 33'(acc[2] - acc[1]), 33'd3);
    chk("b2b_gap23", 33'(acc[3] - acc[2]), 33'd1);
    drain();
    chk("b2b_conf_en", 33'(en_cnt - prev_en), 33'd4);
    chk("b2b_resps", 33'(resp_cnt - prev), 33'd4);

    // Backpressure: two pending, rready low for 5 cycles.
    data_rready = 1'b0;
    issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    issue(1'b0, 2'd2, 32'h0000_0204, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_addr_ok", 33'(data_addr_ok), 33'd0);
      chk("bp_data_ok", 33'(data_data_ok), 33'd1);
      chk("bp_head", {data_err, data_rdata}, exp_q[0]);
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    prev = resp_cnt;
    data_rready = 1'b1;
    drain();
    chk("bp_resps", 33'(resp_cnt - prev), 33'd2);

    // Misaligned half write and reserved size: strobe without side effect, err response.
    issue(1'b1, 2'd1, 32'h0000_2001, 32'h0000_1234);
    @(negedge clk);
    chk("mis_conf_en", 33'(conf_en), 33'd1);
    chk("mis_conf_wen", 33'(conf_wen), 33'd0);
    issue(1'b0, 2'd3, 32'h0000_2000, 32'h0);
    @(negedge clk);
    chk("sz3_conf_en", 33'(conf_en), 33'd1);
    chk("sz3_conf_wen", 33'(conf_wen), 33'd0);
    drain();

    // Reset with two in flight drops them.
    data_rready = 1'b0;
    issue(1'b0, 2'd2, 32'h0000_0400, 32'h0000_0055);
    issue(1'b0, 2'd2, 32'h0000_0404, 32'h0000_0055);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    data_rready = 1'b1;
    @(negedge clk);
    chk("rst2_conf_en", 33'(conf_en), 33'd0);
    chk("rst2_conf_addr", 33'(conf_addr), 33'd0);
    chk("rst2_conf_wdata", 33'(conf_wdata), 33'd0);
    chk("rst2_data_ok", 33'(data_data_ok), 33'd0);
    chk("rst2_rdata_err", {data_err, data_rdata}, 33'd0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_data_ok) k++;
    end
    chk("rst2_no_resp", 33'(k), 33'd0);
    prev = resp_cnt;
    issue(1'b0, 2'd2, 32'h0000_0500, 32'h0);
    drain();
    chk("rst2_new_req", 33'(resp_cnt - prev), 33'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
